lsb_fwd_queue: RTL and testbench

//  Parametrised in-order load/store queue between issue/decode, ROB, CDBs and mem_ctrl.

---
 rtl/lsb_fwd_queue.sv | 254 +++++++++++++++++++++++++
 tb/tb_lsb_fwd_queue.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_fwd_queue.sv
// In-order load/store queue: circular buffer with CDB wake-up, store-ready reporting to the ROB, one memory access at a time.
// Latency: issue to mem_req is 2 cycles for a ready head; st_rdy reported the cycle after a store becomes ready.
// Backpressure: iss_ready drops when full; rdy=0 freezes all state; the head waits in WAIT until mem_done.
module lsb_fwd_queue #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 5,
  parameter int XLEN  = 32,
  parameter int CDB_N = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   iss_valid,
  output logic                   iss_ready,
  input  logic                   iss_store,
  input  logic [2:0]             iss_f3,
  input  logic [TAG_W-1:0]       iss_tag,
  input  logic [XLEN-1:0]        iss_q1,
  input  logic [XLEN-1:0]        iss_q2,
  input  logic                   iss_r1,
  input  logic                   iss_r2,
  input  logic [XLEN-1:0]        iss_imm,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*TAG_W-1:0] cdb_tag,
  input  logic [CDB_N*XLEN-1:0]  cdb_val,
  input  logic                   cmt_valid,
  input  logic [TAG_W-1:0]       cmt_tag,
  output logic                   st_rdy_valid,
  output logic [TAG_W-1:0]       st_rdy_tag,
  output logic                   mem_req_valid,
  output logic                   mem_req_we,
  output logic [2:0]             mem_req_f3,
  output logic [XLEN-1:0]        mem_req_addr,
  output logic [XLEN-1:0]        mem_req_data,
  output logic [TAG_W-1:0]       mem_req_tag,
  input  logic                   mem_done,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic             vld;
    logic             store;
    logic [2:0]       f3;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  q1;
    logic [XLEN-1:0]  q2;
    logic [XLEN-1:0]  imm;
    logic             r1;
    logic             r2;
    logic             cmt;
    logic             rep;
  } ent_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;

  logic             st_rdy_valid_q, st_rdy_valid_d;
  logic [TAG_W-1:0] st_rdy_tag_q, st_rdy_tag_d;
  logic             mem_req_valid_q, mem_req_valid_d;
  logic             mem_req_we_q, mem_req_we_d;
  logic [2:0]       mem_req_f3_q, mem_req_f3_d;
  logic [XLEN-1:0]  mem_req_addr_q, mem_req_addr_d;
  logic [XLEN-1:0]  mem_req_data_q, mem_req_data_d;
  logic [TAG_W-1:0] mem_req_tag_q, mem_req_tag_d;

  // scratch for the next-state logic
  logic [PTR_W-1:0] idx;
  logic             found, keep_run, do_issue, do_pop;
  logic [CNT_W-1:0] kept;
  logic [XLEN:0]    wk;
  ent_t             hd, nw;

  assign iss_ready     = (count_q < CNT_W'(DEPTH));
  assign empty         = (count_q == '0);
  assign st_rdy_valid  = st_rdy_valid_q;
  assign st_rdy_tag    = st_rdy_tag_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we    = mem_req_we_q;
  assign mem_req_f3    = mem_req_f3_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_data  = mem_req_data_q;
  assign mem_req_tag   = mem_req_tag_q;

  // Capture an operand from the CDB; scanning high to low lets channel 0 win ties.
  function automatic logic [XLEN:0] wake_op(
    input logic                   r,
    input logic [XLEN-1:0]        q,
    input logic [CDB_N-1:0]       cv,
    input logic [CDB_N*TAG_W-1:0] ct,
    input logic [CDB_N*XLEN-1:0]  cval
  );
    logic [XLEN:0] res;
    res = {r, q};
    if (!r) begin
      for (int c = CDB_N - 1; c >= 0; c--) begin
        if (cv[c] && (ct[c*TAG_W +: TAG_W] == q[TAG_W-1:0])) begin
          res = {1'b1, cval[c*XLEN +: XLEN]};
        end
      end
    end
    return res;
  endfunction

  // Next-state: wake-up, commit, store report, head FSM, then issue or selective flush.
  always_comb begin
    ent_d           = ent_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    state_d         = state_q;
    st_rdy_valid_d  = 1'b0;
    st_rdy_tag_d    = st_rdy_tag_q;
    mem_req_valid_d = 1'b0;
    mem_req_we_d    = mem_req_we_q;
    mem_req_f3_d    = mem_req_f3_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_data_d  = mem_req_data_q;
    mem_req_tag_d   = mem_req_tag_q;
    idx             = '0;
    found           = 1'b0;
    keep_run        = 1'b0;
    do_issue        = 1'b0;
    do_pop          = 1'b0;
    kept            = '0;
    wk              = '0;
    hd              = ent_q[head_q];
    nw              = '0;

    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].vld) begin
          wk = wake_op(ent_q[i].r1, ent_q[i].q1, cdb_valid, cdb_tag, cdb_val);
          ent_d[i].r1 = wk[XLEN];
          ent_d[i].q1 = wk[XLEN-1:0];
          wk = wake_op(ent_q[i].r2, ent_q[i].q2, cdb_valid, cdb_tag, cdb_val);
          ent_d[i].r2 = wk[XLEN];
          ent_d[i].q2 = wk[XLEN-1:0];
          if (cmt_valid && ent_q[i].store && (ent_q[i].tag == cmt_tag)) begin
            ent_d[i].cmt = 1'b1;
          end
        end
      end

      // Oldest unreported ready store; skipped on flush since the ROB is squashing anyway.
      if (!flush) begin
        for (int k = 0; k < DEPTH; k++) begin
          idx = head_q + PTR_W'(k);
          if (!found && ent_q[idx].vld && ent_q[idx].store && ent_q[idx].r1 &&
              ent_q[idx].r2 && !ent_q[idx].rep) begin
            found              = 1'b1;
            ent_d[idx].rep     = 1'b1;
            st_rdy_valid_d     = 1'b1;
            st_rdy_tag_d       = ent_q[idx].tag;
          end
        end
      end

      // During a flush in IDLE only a committed-store head survives, so only it may launch.
      if (state_q == S_IDLE) begin
        if (hd.vld && ((!hd.store && hd.r1) || (hd.store && hd.cmt)) && (!flush || hd.store)) begin
          state_d         = S_WAIT;
          mem_req_valid_d = 1'b1;
          mem_req_we_d    = hd.store;
          mem_req_f3_d    = hd.f3;
          mem_req_addr_d  = hd.q1 + hd.imm;
          mem_req_data_d  = hd.store ? hd.q2 : '0;
          mem_req_tag_d   = hd.tag;
        end
      end else if (mem_done) begin
        do_pop              = 1'b1;
        state_d             = S_IDLE;
        ent_d[head_q].vld   = 1'b0;
        head_d              = head_q + PTR_W'(1);
      end

      if (flush) begin
        keep_run = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
          idx = head_q + PTR_W'(k);
          if (keep_run && ent_q[idx].vld &&
              (((k == 0) && (state_q == S_WAIT)) || (ent_d[idx].store && ent_d[idx].cmt))) begin
            kept = kept + CNT_W'(1);
          end else begin
            keep_run       = 1'b0;
            ent_d[idx].vld = 1'b0;
          end
        end
        tail_d  = head_q + kept[PTR_W-1:0];
        count_d = kept - CNT_W'(do_pop);
      end else begin
        do_issue = iss_valid && iss_ready;
        if (do_issue) begin
          nw.vld   = 1'b1;
          nw.store = iss_store;
          nw.f3    = iss_f3;
          nw.tag   = iss_tag;
          nw.imm   = iss_imm;
          wk       = wake_op(iss_r1, iss_q1, cdb_valid, cdb_tag, cdb_val);
          nw.r1    = wk[XLEN];
          nw.q1    = wk[XLEN-1:0];
          wk       = wake_op(iss_r2, iss_q2, cdb_valid, cdb_tag, cdb_val);
          nw.r2    = wk[XLEN];
          nw.q2    = wk[XLEN-1:0];
          ent_d[tail_q] = nw;
          tail_d   = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_issue) - CNT_W'(do_pop);
      end
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      state_q         <= S_IDLE;
      st_rdy_valid_q  <= 1'b0;
      st_rdy_tag_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_f3_q    <= '0;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
      mem_req_tag_q   <= '0;
    end else begin
      ent_q           <= ent_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      state_q         <= state_d;
      st_rdy_valid_q  <= st_rdy_valid_d;
      st_rdy_tag_q    <= st_rdy_tag_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_f3_q    <= mem_req_f3_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_data_q  <= mem_req_data_d;
      mem_req_tag_q   <= mem_req_tag_d;
    end
  end

endmodule

// File: tb/tb_lsb_fwd_queue.sv
// Bench for lsb_fwd_queue: directed stimulus, expected memory requests and store
// reports are queued at stimulus time and checked by a separate negedge monitor.
module tb_lsb_fwd_queue;
  localparam int DEPTH = 16;
  localparam int TAG_W = 5;
  localparam int XLEN  = 32;
  localparam int CDB_N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, rdy, flush, iss_valid, iss_ready, iss_store;
  logic [2:0]             iss_f3;
  logic [TAG_W-1:0]       iss_tag;
  logic [XLEN-1:0]        iss_q1, iss_q2, iss_imm;
  logic                   iss_r1, iss_r2;
  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*XLEN-1:0]  cdb_val;
  logic                   cmt_valid;
  logic [TAG_W-1:0]       cmt_tag;
  logic                   st_rdy_valid;
  logic [TAG_W-1:0]       st_rdy_tag;
  logic                   mem_req_valid, mem_req_we;
  logic [2:0]             mem_req_f3;
  logic [XLEN-1:0]        mem_req_addr, mem_req_data;
  logic [TAG_W-1:0]       mem_req_tag;
  logic                   mem_done, empty;

  lsb_fwd_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .CDB_N(CDB_N)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_store(iss_store), .iss_f3(iss_f3),
    .iss_tag(iss_tag), .iss_q1(iss_q1), .iss_q2(iss_q2), .iss_r1(iss_r1), .iss_r2(iss_r2),
    .iss_imm(iss_imm), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cmt_valid(cmt_valid), .cmt_tag(cmt_tag), .st_rdy_valid(st_rdy_valid), .st_rdy_tag(st_rdy_tag),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_f3(mem_req_f3),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_done(mem_done), .empty(empty)
  );

  typedef struct packed {
    logic             we;
    logic [2:0]       f3;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
  } mreq_t;

  mreq_t            exp_mem [$];
  logic [TAG_W-1:0] exp_st  [$];
  mreq_t            m_got, m_want;
  logic [TAG_W-1:0] s_want;
  int total = 0;
  int bad   = 0;

  // Monitor: every output pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (mem_req_valid === 1'b1) begin
      total++;
      m_got = '{mem_req_we, mem_req_f3, mem_req_addr, mem_req_data, mem_req_tag};
      if (exp_mem.size() == 0) begin
        bad++;
        $display("FAIL mem_req_unexpected: got %h, none expected", m_got);
      end else begin
        m_want = exp_mem.pop_front();
        if (m_got !== m_want) begin
          bad++;
          $display("FAIL mem_req: got we=%b f3=%b addr=%h data=%h tag=%0d, expected we=%b f3=%b addr=%h data=%h tag=%0d",
                   m_got.we, m_got.f3, m_got.addr, m_got.data, m_got.tag,
                   m_want.we, m_want.f3, m_want.addr, m_want.data, m_want.tag);
        end
      end
    end
    if (st_rdy_valid === 1'b1) begin
      total++;
      if (exp_st.size() == 0) begin
        bad++;
        $display("FAIL st_rdy_unexpected: got tag %0d, none expected", st_rdy_tag);
      end else begin
        s_want = exp_st.pop_front();
        if (st_rdy_tag !== s_want) begin
          bad++;
          $display("FAIL st_rdy: got tag %0d, expected %0d", st_rdy_tag, s_want);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    iss_valid = 1'b0;
    flush     = 1'b0;
    mem_done  = 1'b0;
    cmt_valid = 1'b0;
    cdb_valid = '0;
  endtask

  task automatic set_iss(input logic st, input logic [2:0] f3, input logic [TAG_W-1:0] tag,
                         input logic [XLEN-1:0] q1, input logic r1,
                         input logic [XLEN-1:0] q2, input logic r2, input logic [XLEN-1:0] imm);
    iss_valid = 1'b1;
    iss_store = st;
    iss_f3    = f3;
    iss_tag   = tag;
    iss_q1    = q1;
    iss_r1    = r1;
    iss_q2    = q2;
    iss_r2    = r2;
    iss_imm   = imm;
  endtask

  task automatic exp_m(input logic we, input logic [2:0] f3, input logic [XLEN-1:0] addr,
                       input logic [XLEN-1:0] data, input logic [TAG_W-1:0] tag);
    exp_mem.push_back('{we, f3, addr, data, tag});
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    total++;
    if (mem_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL wait_req: mem_req_valid=%b after %0d cycles, expected 1", mem_req_valid, n);
    end
  endtask

  task automatic serve();
    wait_req();
    mem_done = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_store = 1'b0; iss_f3 = '0;
    iss_tag = '0; iss_q1 = '0; iss_q2 = '0; iss_r1 = 1'b0; iss_r2 = 1'b0; iss_imm = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0; cmt_valid = 1'b0; cmt_tag = '0; mem_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_iss_ready", iss_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_st_rdy_valid", st_rdy_valid, 0);
    rst = 1'b0;
    step();

    // LW with ready base: request exactly 2 cycles after issue.
    exp_m(1'b0, 3'b010, 32'h0000_00FC, 32'h0, 5'd1);
    set_iss(1'b0, 3'b010, 5'd1, 32'h100, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);
    step();
    chk("lw_lat1", mem_req_valid, 0);
    step();
    chk("lw_lat2", mem_req_valid, 1);
    chk("lw_busy_empty", empty, 0);
    mem_done = 1'b1;
    step();
    chk("lw_pop_empty", empty, 1);

    // SW with both operands woken by two CDB channels.
    exp_st.push_back(5'd2);
    set_iss(1'b1, 3'b010, 5'd2, 32'd3, 1'b0, 32'd4, 1'b0, 32'd8);
    step();
    cdb_valid = 2'b11;
    cdb_tag   = {5'd3, 5'd4};
    cdb_val   = {32'h20, 32'hAB};
    step();
    repeat (4) step();
    exp_m(1'b1, 3'b010, 32'h28, 32'hAB, 5'd2);
    cmt_valid = 1'b1;
    cmt_tag   = 5'd2;
    step();
    serve();
    chk("sw_empty", empty, 1);

    // Fill to full; pop while full must not admit an issue.
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) begin
        exp_m(1'b0, 3'b010, 32'h1000, 32'h0, 5'd0);
        set_iss(1'b0, 3'b010, 5'd0, 32'h1000, 1'b1, 32'h0, 1'b1, 32'h0);
      end else if (i == 1) begin
        exp_m(1'b0, 3'b100, 32'h1004, 32'h0, 5'd1);
        set_iss(1'b0, 3'b100, 5'd1, 32'h1000, 1'b1, 32'h0, 1'b1, 32'h4);
      end else begin
        exp_m(1'b0, 3'b001, 32'h2000 + 32'(4 * i), 32'h0, 5'(i));
        set_iss(1'b0, 3'b001, 5'(i), 32'd30, 1'b0, 32'h0, 1'b1, 32'(4 * i));
      end
      step();
    end
    chk("full_iss_ready", iss_ready, 0);
    chk("full_empty", empty, 0);
    set_iss(1'b0, 3'b010, 5'd20, 32'h9000, 1'b1, 32'h0, 1'b1, 32'h0);
    mem_done = 1'b1;
    step();
    chk("full_pop_ready", iss_ready, 1);
    wait_req();
    exp_m(1'b0, 3'b010, 32'h3000, 32'h0, 5'd21);
    set_iss(1'b0, 3'b010, 5'd21, 32'h3000, 1'b1, 32'h0, 1'b1, 32'h0);
    mem_done = 1'b1;
    step();
    chk("push_pop_ready", iss_ready, 1);
    exp_m(1'b0, 3'b010, 32'h3004, 32'h0, 5'd22);
    set_iss(1'b0, 3'b010, 5'd22, 32'h3004, 1'b1, 32'h0, 1'b1, 32'h0);
    step();
    chk("refill_iss_ready", iss_ready, 0);
    cdb_valid = 2'b11;
    cdb_tag   = {5'd30, 5'd30};
    cdb_val   = {32'hDEAD, 32'h2000};
    step();
    for (int i = 0; i < DEPTH; i++) serve();
    chk("drain_empty", empty, 1);

    // Selective flush: two committed stores survive, the rest are dropped.
    exp_st.push_back(5'd1);
    exp_st.push_back(5'd2);
    exp_st.push_back(5'd4);
    set_iss(1'b1, 3'b010, 5'd1, 32'h100, 1'b1, 32'h11, 1'b1, 32'h0); step();
    set_iss(1'b1, 3'b001, 5'd2, 32'h104, 1'b1, 32'h22, 1'b1, 32'h0); step();
    set_iss(1'b0, 3'b010, 5'd3, 32'd29,  1'b0, 32'h0,  1'b1, 32'h0); step();
    set_iss(1'b1, 3'b010, 5'd4, 32'h200, 1'b1, 32'h44, 1'b1, 32'h0); step();
    set_iss(1'b0, 3'b010, 5'd5, 32'd29,  1'b0, 32'h0,  1'b1, 32'h0); step();
    repeat (4) step();
    exp_m(1'b1, 3'b010, 32'h100, 32'h11, 5'd1);
    exp_m(1'b1, 3'b001, 32'h104, 32'h22, 5'd2);
    cmt_valid = 1'b1;
    cmt_tag   = 5'd1;
    step();
    flush     = 1'b1;
    cmt_valid = 1'b1;
    cmt_tag   = 5'd2;
    set_iss(1'b0, 3'b010, 5'd9, 32'h900, 1'b1, 32'h0, 1'b1, 32'h0);
    step();
    chk("flush_empty", empty, 0);
    serve();
    chk("flush_one_left", empty, 0);
    serve();
    chk("flush_drained", empty, 1);
    repeat (5) step();

    // Same-cycle CDB bypass, then flush while the head load is in flight.
    exp_m(1'b0, 3'b010, 32'h510, 32'h0, 5'd7);
    set_iss(1'b0, 3'b010, 5'd7, 32'd6, 1'b0, 32'h0, 1'b1, 32'h10);
    cdb_valid = 2'b01;
    cdb_tag   = {5'd0, 5'd6};
    cdb_val   = {32'h0, 32'h500};
    step();
    chk("byp_lat1", mem_req_valid, 0);
    set_iss(1'b0, 3'b010, 5'd8, 32'h600, 1'b1, 32'h0, 1'b1, 32'h0);
    step();
    chk("byp_lat2", mem_req_valid, 1);
    flush = 1'b1;
    step();
    chk("wait_flush_kept", empty, 0);
    mem_done = 1'b1;
    step();
    chk("wait_flush_popped", empty, 1);
    repeat (5) step();

    // Pointer wrap with rdy toggling; a rdy=0 cycle must not launch or accept anything.
    for (int i = 0; i < 20; i++) begin
      exp_m(1'b0, 3'b000, 32'h4000 + 32'(17 * (2 * i)), 32'h0, 5'(2 * i));
      set_iss(1'b0, 3'b000, 5'(2 * i), 32'h4000 + 32'(16 * (2 * i)), 1'b1, 32'h0, 1'b1, 32'(2 * i));
      step();
      rdy = 1'b0;
      set_iss(1'b0, 3'b010, 5'd31, 32'hBAD, 1'b1, 32'h0, 1'b1, 32'h0);
      mem_done = 1'b1;
      step();
      rdy = 1'b1;
      chk("rdy_low_hold", mem_req_valid, 0);
      exp_m(1'b0, 3'b101, 32'h4000 + 32'(17 * (2 * i + 1)), 32'h0, 5'(2 * i + 1));
      set_iss(1'b0, 3'b101, 5'(2 * i + 1), 32'h4000 + 32'(16 * (2 * i + 1)), 1'b1, 32'h0, 1'b1,
              32'(2 * i + 1));
      step();
      serve();
      serve();
      chk("wrap_empty", empty, 1);
    end

    // Reset while waiting on memory; the late mem_done must be ignored.
    exp_m(1'b0, 3'b010, 32'h700, 32'h0, 5'd10);
    set_iss(1'b0, 3'b010, 5'd10, 32'h700, 1'b1, 32'h0, 1'b1, 32'h0);
    step();
    step();
    chk("rstw_req", mem_req_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_empty", empty, 1);
    mem_done = 1'b1;
    step();
    chk("rstw_late_done_empty", empty, 1);
    chk("rstw_iss_ready", iss_ready, 1);
    exp_m(1'b0, 3'b010, 32'h800, 32'h0, 5'd11);
    set_iss(1'b0, 3'b010, 5'd11, 32'h800, 1'b1, 32'h0, 1'b1, 32'h0);
    step();
    serve();
    chk("rstw_final_empty", empty, 1);

    repeat (5) step();
    chk("exp_mem_left", exp_mem.size(), 0);
    chk("exp_st_left", exp_st.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
